// File: rtl/mem_reader.sv
// mem_reader: vector load stage. On start it issues NoOfElem sequential
// single-word BRAM reads from a latched base address. The returned words are
// gathered into one packed vector, and completion is flagged with a
// one-cycle RDdone pulse.
module mem_reader #(
  parameter int NoOfElem    = 16,
  parameter int wordSize    = 32,
  parameter int memDepth    = 9,
  parameter int readLatency = 1
) (
  input  logic                               clk,
  input  logic                               RESET,
  input  logic                               start,
  input  logic [memDepth-1:0]                baseAddr,
  input  logic [wordSize-1:0]                dataInBRAM,
  output logic [memDepth-1:0]                readAddrBRAM,
  output logic                               readEN,
  output logic [NoOfElem-1:0][wordSize-1:0]  dataOut,
  output logic                               busy,
  output logic                               RDdone
);

  localparam int IW = $clog2(NoOfElem);
  localparam int CW = IW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]          state;
  logic [CW-1:0]       issueCnt;
  logic [memDepth-1:0] baseReg;
  logic [IW-1:0]       readIdx;

  logic                pipeValid [readLatency];
  logic [IW-1:0]       pipeIdx   [readLatency];

  logic                tailValid;
  logic [IW-1:0]       tailIdx;
  logic                lastCapture;

  assign tailValid   = pipeValid[readLatency-1];
  assign tailIdx     = pipeIdx[readLatency-1];
  assign lastCapture = tailValid && (tailIdx == IW'(NoOfElem - 1));

  assign busy   = (state != IDLE);
  assign RDdone = (state == DONE);

  // Control FSM and registered read port. The read for element 0 is presented
  // on the accepting edge itself, so the counter starts at 1 there. The
  // counter MSB then means "all reads issued".
  always_ff @(posedge clk) begin
    if (RESET) begin
      state        <= IDLE;
      issueCnt     <= '0;
      baseReg      <= '0;
      readIdx      <= '0;
      readEN       <= 1'b0;
      readAddrBRAM <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            baseReg      <= baseAddr;
            readAddrBRAM <= baseAddr;
            readIdx      <= '0;
            readEN       <= 1'b1;
            issueCnt     <= CW'(1);
            state        <= ISSUE;
          end else begin
            readEN <= 1'b0;
            state  <= IDLE;
          end
        end
        ISSUE: begin
          if (issueCnt[CW-1]) begin
            readEN <= 1'b0;
            state  <= DRAIN;
          end else begin
            readEN       <= 1'b1;
            readAddrBRAM <= baseReg + memDepth'(issueCnt[IW-1:0]);
            readIdx      <= issueCnt[IW-1:0];
            issueCnt     <= issueCnt + CW'(1);
          end
        end
        DRAIN: begin
          if (lastCapture) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tracks (valid, element index) for each read until its data returns.
  always_ff @(posedge clk) begin
    if (RESET) begin
      for (int i = 0; i < readLatency; i++) begin
        pipeValid[i] <= 1'b0;
        pipeIdx[i]   <= '0;
      end
    end else begin
      pipeValid[0] <= readEN;
      pipeIdx[0]   <= readIdx;
      for (int i = 1; i < readLatency; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeIdx[i]   <= pipeIdx[i-1];
      end
    end
  end

  // Writes each returning word into its slot. Other slots keep their contents.
  always_ff @(posedge clk) begin
    if (RESET) begin
      dataOut <= '0;
    end else if (tailValid) begin
      dataOut[tailIdx] <= dataInBRAM;
    end
  end

endmodule

// File: tb/tb_mem_reader.sv
// tb_mem_reader: drives two mem_reader instances (read latency 1 and 3) that
// share a BRAM content array. It checks every cycle of each load against
// expectations derived from the load's base address and the memory contents.
module tb_mem_reader;

  localparam int N = 16;
  localparam int W = 32;
  localparam int D = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         RESET;
  logic         start;
  logic         sel;
  logic [D-1:0] baseAddr;

  logic               start1, start3;
  logic [D-1:0]       readAddr1, readAddr3;
  logic               readEN1, readEN3;
  logic [N-1:0][W-1:0] dataOut1, dataOut3;
  logic               busy1, busy3, RDdone1, RDdone3;
  logic [W-1:0]       dataIn1, dataIn3, p0, p1;

  logic [W-1:0] mem [512];

  int testCount = 0;
  int failCount = 0;

  assign start1 = start & ~sel;
  assign start3 = start & sel;

  mem_reader #(.NoOfElem(N), .wordSize(W), .memDepth(D), .readLatency(1)) dut1 (
    .clk(clk), .RESET(RESET), .start(start1), .baseAddr(baseAddr),
    .dataInBRAM(dataIn1), .readAddrBRAM(readAddr1), .readEN(readEN1),
    .dataOut(dataOut1), .busy(busy1), .RDdone(RDdone1)
  );

  mem_reader #(.NoOfElem(N), .wordSize(W), .memDepth(D), .readLatency(3)) dut3 (
    .clk(clk), .RESET(RESET), .start(start3), .baseAddr(baseAddr),
    .dataInBRAM(dataIn3), .readAddrBRAM(readAddr3), .readEN(readEN3),
    .dataOut(dataOut3), .busy(busy3), .RDdone(RDdone3)
  );

  // BRAM with one cycle of read latency
  always @(posedge clk) begin
    if (readEN1) dataIn1 <= mem[readAddr1];
  end

  // BRAM with three cycles of read latency
  always @(posedge clk) begin
    if (readEN3) p0 <= mem[readAddr3];
    p1      <= p0;
    dataIn3 <= p1;
  end

  logic               obsEN, obsBusy, obsDone;
  logic [D-1:0]       obsAddr;
  logic [N-1:0][W-1:0] obsData;
  assign obsEN   = sel ? readEN3   : readEN1;
  assign obsAddr = sel ? readAddr3 : readAddr1;
  assign obsBusy = sel ? busy3     : busy1;
  assign obsDone = sel ? RDdone3   : RDdone1;
  assign obsData = sel ? dataOut3  : dataOut1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " busy"},   {31'd0, obsBusy}, 32'd0);
    checkOutput({tag, " RDdone"}, {31'd0, obsDone}, 32'd0);
    checkOutput({tag, " readEN"}, {31'd0, obsEN},   32'd0);
  endtask

  // One full load: start is accepted at the next edge (E0). Each cycle up
  // to the RDdone cycle is checked. A second start with base 100 can be pulsed
  // into edge glitchAt (-1 = none). The task returns in the RDdone cycle.
  task automatic applyStimulus(input logic [D-1:0] base, input int lat, input int glitchAt);
    logic [W-1:0] expv [N];
    for (int k = 0; k < N; k++) expv[k] = mem[(int'(base) + k) % 512];
    start    = 1'b1;
    baseAddr = base;
    for (int j = 0; j <= N + lat; j++) begin
      tick;
      if (glitchAt >= 0 && j == glitchAt - 1) begin
        start    = 1'b1;
        baseAddr = 9'd100;
      end else begin
        start = 1'b0;
      end
      checkOutput($sformatf("readEN E%0d", j), {31'd0, obsEN}, (j < N) ? 32'd1 : 32'd0);
      if (j < N)
        checkOutput($sformatf("addr E%0d", j), {23'd0, obsAddr}, 32'((int'(base) + j) % 512));
      checkOutput($sformatf("RDdone E%0d", j), {31'd0, obsDone}, (j == N + lat) ? 32'd1 : 32'd0);
      checkOutput($sformatf("busy E%0d", j), {31'd0, obsBusy}, 32'd1);
    end
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("dataOut[%0d] base %0d", k, base), obsData[k], expv[k]);
  endtask

  // Starts a load, hits reset after E8 and verifies the load is abandoned.
  task automatic resetMidLoad(input logic [D-1:0] base);
    start    = 1'b1;
    baseAddr = base;
    for (int j = 0; j <= 8; j++) begin
      tick;
      start = 1'b0;
    end
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    checkIdle("after reset");
    checkOutput("after reset addr", {23'd0, obsAddr}, 32'd0);
    for (int k = 0; k < N; k++)
      checkOutput($sformatf("after reset dataOut[%0d]", k), obsData[k], 32'd0);
    for (int j = 0; j < 20; j++) begin
      tick;
      checkOutput("no RDdone after reset", {31'd0, obsDone}, 32'd0);
    end
  endtask

  initial begin
    RESET    = 1'b1;
    start    = 1'b0;
    sel      = 1'b0;
    baseAddr = '0;
    for (int a = 0; a < 512; a++) mem[a] = 32'(3 * a + 1);
    tick;
    tick;
    RESET = 1'b0;
    checkIdle("reset lat1");
    checkOutput("reset addr lat1", {23'd0, obsAddr}, 32'd0);
    checkOutput("reset dataOut lat1", obsData[0], 32'd0);
    sel = 1'b1;
    #1;
    checkIdle("reset lat3");
    checkOutput("reset dataOut lat3", obsData[N-1], 32'd0);
    sel = 1'b0;
    tick;

    $display("[TB] basic load");
    applyStimulus(9'd0, 1, -1);
    tick;
    checkIdle("after basic");

    $display("[TB] wrap-around");
    applyStimulus(9'd511, 1, -1);
    checkOutput("wrap dataOut[0]", obsData[0], 32'd1534);
    checkOutput("wrap dataOut[1]", obsData[1], 32'd1);
    tick;
    checkIdle("after wrap");

    $display("[TB] start while busy");
    applyStimulus(9'd0, 1, 5);
    tick;
    checkIdle("after ignored start");

    $display("[TB] back-to-back");
    applyStimulus(9'd0, 1, -1);
    applyStimulus(9'd32, 1, -1);
    tick;
    checkIdle("after back-to-back");

    $display("[TB] reset mid-load");
    resetMidLoad(9'd40);
    applyStimulus(9'd7, 1, -1);
    tick;
    checkIdle("after reset recovery");

    $display("[TB] latency 3");
    sel = 1'b1;
    tick;
    applyStimulus(9'd0, 3, -1);
    tick;
    checkIdle("after latency 3");

    $display("[TB] randomized loads");
    for (int a = 0; a < 512; a++) mem[a] = $urandom;
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      tick;
      applyStimulus(9'($urandom_range(0, 511)), sel ? 3 : 1, -1);
      if ($urandom_range(0, 1) == 1)
        applyStimulus(9'($urandom_range(0, 511)), sel ? 3 : 1, -1);
      tick;
      checkIdle("after random load");
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mem_reader.md
# mem_reader

Vector load stage upstream of the write-back path. On a start pulse it issues `NoOfElem` sequential single-word reads to the block RAM from a base address. It collects the returned words, accounting for the configured BRAM read latency, into one `NoOfElem`-wide vector for the processing elements. It signals completion with a one-cycle done pulse and holds the vector stable until the next load.

## Interface

**Parameters**
- `NoOfElem`, 16: words per vector; must be a power of two and ≥2.
- `wordSize`, 32: BRAM data width and element width.
- `memDepth`, 9: BRAM address width.
- `readLatency`, 1: cycles from the BRAM sampling an address to valid `dataInBRAM`; legal range 1–3.

**Ports**
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `RESET`, input, 1: synchronous, active-high reset.
- `start`, input, 1: load request. Sampled only in IDLE or DONE.
- `baseAddr`, input, `memDepth`: first BRAM address. Latched when `start` is accepted.
- `dataInBRAM`, input, `wordSize`: BRAM read data.
- `readAddrBRAM`, output, `memDepth`: BRAM read address.
- `readEN`, output, 1: BRAM read enable.
- `dataOut`, output, `[NoOfElem-1:0][wordSize-1:0]`: assembled vector. Element k holds the word read from `baseAddr+k`.
- `busy`, output, 1: high whenever the state is not IDLE.
- `RDdone`, output, 1: one-cycle pulse; `dataOut` is complete while it is high.

## Operation

**States**
- **IDLE**
  - `start`=1: latch `baseAddr`, clear the issue counter, go to ISSUE.
- **ISSUE**
  - Each cycle: `readEN`=1, `readAddrBRAM` = latched base + issue count, issue count increments.
  - After `NoOfElem` issues: go to DRAIN, `readEN`=0.
- **DRAIN**
  - Wait until all outstanding returns are captured.
  - Go to DONE in the same edge that captures the last word.
- **DONE**
  - Lasts exactly one cycle, with `RDdone`=1.
  - `start`=1: behave as in IDLE and go to ISSUE (back-to-back load).
  - Otherwise: go to IDLE.

**Capture pipeline**
- A `readLatency`-deep shift register carries (valid, element index) for each issued read.
- When the tail is valid, `dataInBRAM` is written into `dataOut[index]`.
- Other elements are untouched. Elements not yet rewritten by a new load keep their previous values.

**Arithmetic and width**
- Issue counter width is `$clog2(NoOfElem)+1`; the MSB marks that issuing is finished.
- Address addition is modulo 2^`memDepth`. Base 511 with depth 9 issues 511, 0, 1, …, 14.

**Other rules**
- `start` in ISSUE or DRAIN is ignored, with no side effects.
- `readEN`=0 outside ISSUE, and `readAddrBRAM` holds its last value.

**Reset**
- Applies at any time, including mid-load.
- Next state is IDLE and the capture pipeline is flushed.
- Outputs:
  - `dataOut`=0
  - `readAddrBRAM`=0
  - `readEN`=0
  - `busy`=0
  - `RDdone`=0
- Read returns still in flight after reset are discarded.

## Timing

- Let E0 be the edge that accepts `start`. Edge Ej is j edges later.
- `readEN`/`readAddrBRAM` are registered.
  - Read k (k = 0 … `NoOfElem`-1) is presented after E(k), so the BRAM samples it at E(k+1).
  - Word k is captured at E(k+1+`readLatency`).
- `RDdone` and the final capture both occur at E(`NoOfElem`+`readLatency`).
  - `RDdone` is high for the cycle following that edge.
  - Defaults: the final capture is at E17, and `RDdone` is high in the cycle after E17.
- `busy` rises after E0 and falls after E(`NoOfElem`+`readLatency`+1), unless a back-to-back `start` occurs.
- Throughput: back-to-back loads take `NoOfElem`+`readLatency`+1 cycles each, with no idle gap.
- There is no combinational path from any input to any output.

## Test plan

1. **Basic load:** BRAM model with mem[a]=3a+1, `baseAddr`=0, defaults.
   - Expect `readEN` high for 16 cycles, addresses 0–15.
   - Expect `RDdone` for one cycle after E17, with `dataOut[k]`=3k+1.
   - Expect `busy` low after E18.
2. **Wrap-around:** `baseAddr`=511.
   - Expect addresses 511, 0 … 14.
   - Expect `dataOut[0]`=1534 and `dataOut[1]`=1.
3. **Start while busy:** `start` pulsed at E5 with `baseAddr`=100.
   - Expect it ignored: addresses still continue 6, 7, …, and the result is identical to scenario 1.
4. **Back-to-back:** second `start` with `baseAddr`=32 asserted during the `RDdone` cycle.
   - Expect `readEN` again after the next edge, with no idle cycle.
   - Expect the second `RDdone` 18 cycles after the first, with `dataOut[k]`=3(32+k)+1.
5. **Reset mid-load:** `RESET` asserted after E8 for one cycle.
   - Expect all outputs 0 next cycle and no `RDdone`.
   - A new load then completes correctly.
6. **Latency variant:** `readLatency`=3, BRAM model delayed by 3.
   - Expect `RDdone` after E19 with correct data.
